// File: rtl/ddr2_arb_pkg.sv
// Shared constants for the DDR2 command arbiter: command codes, FSM state
// encoding and the write/read direction encoding.
package ddr2_arb_pkg;

   localparam logic [1:0] CMD_NONE = 2'd0;
   localparam logic [1:0] CMD_WR   = 2'd1;
   localparam logic [1:0] CMD_RD   = 2'd2;
   localparam logic [1:0] CMD_REF  = 2'd3;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ARB       = 2'd1;
   localparam logic [1:0] ST_ISSUE     = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   localparam logic DIR_WR = 1'b0;
   localparam logic DIR_RD = 1'b1;

   function automatic logic [1:0] dir_to_cmd(input logic dir);
      if (dir == DIR_RD) begin
         return CMD_RD;
      end else begin
         return CMD_WR;
      end
   endfunction

endpackage

// File: rtl/ddr2_arb_watchdog.sv
// Completion watchdog for the arbiter: counts enabled cycles since the last
// clear and pulses expire on the TIMEOUT_CYCLES-th one. Used with ARB_TIMEOUT_EN.
module ddr2_arb_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_r;

   assign expire = en && (cnt_r == LAST_CNT);

   // cycle counter, held once expired so it cannot wrap
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (en && !expire) begin
         cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/ddr2_cmd_arbiter.sv
// Refresh/write/read command arbiter in front of the DDR2 command sequencer.
// Optional completion watchdog enabled by defining ARB_TIMEOUT_EN.
module ddr2_cmd_arbiter
   import ddr2_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 26,
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  init_end,
   input  logic                  ref_req,
   output logic                  ref_ack,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   output logic                  wr_ack,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_ack,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [1:0]            cmd_type,
   output logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic                  cmd_done,
   output logic                  busy,
   output logic                  err_timeout
);

   localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("ddr2_cmd_arbiter: STARVE_LIMIT or TIMEOUT_CYCLES out of range");
   end

   logic [1:0]            state_r;
   logic [3:0]            streak_r;
   logic                  last_dir_r;
   logic [1:0]            grant_type_s;
   logic [ADDR_WIDTH-1:0] grant_addr_s;
   logic                  grant_dir_s;
   logic [3:0]            streak_nxt_s;
   logic                  handshake_s;
   logic                  wd_expire_s;

   assign handshake_s = (state_r == ST_ISSUE) && cmd_valid && cmd_ready;

   // request selection: refresh first, then direction with bounded streak
   always_comb begin
      grant_type_s = CMD_NONE;
      grant_addr_s = '0;
      grant_dir_s  = last_dir_r;
      if (ref_req) begin
         grant_type_s = CMD_REF;
      end else if (wr_req || rd_req) begin
         if (wr_req && rd_req) begin
            if (streak_r < STREAK_MAX) begin
               grant_dir_s = last_dir_r;
            end else begin
               grant_dir_s = ~last_dir_r;
            end
         end else if (rd_req) begin
            grant_dir_s = DIR_RD;
         end else begin
            grant_dir_s = DIR_WR;
         end
         grant_type_s = dir_to_cmd(grant_dir_s);
         grant_addr_s = (grant_dir_s == DIR_RD) ? rd_addr : wr_addr;
      end else begin
         grant_type_s = CMD_NONE;
      end
   end

   // streak after a WR/RD grant: restart on turnaround, saturate otherwise
   always_comb begin
      if (grant_dir_s != last_dir_r) begin
         streak_nxt_s = 4'd1;
      end else if (streak_r >= STREAK_MAX) begin
         streak_nxt_s = STREAK_MAX;
      end else begin
         streak_nxt_s = streak_r + 4'd1;
      end
   end

`ifdef ARB_TIMEOUT_EN
   ddr2_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (sys_clk),
      .rst_n  (sys_rst_n),
      .clr    (handshake_s),
      .en     ((state_r == ST_WAIT_DONE) && !cmd_done),
      .expire (wd_expire_s)
   );
`else
   assign wd_expire_s = 1'b0;
`endif

   // arbiter FSM with registered command, ack and status outputs
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_r     <= ST_IDLE;
         streak_r    <= 4'd0;
         last_dir_r  <= DIR_WR;
         cmd_valid   <= 1'b0;
         cmd_type    <= CMD_NONE;
         cmd_addr    <= '0;
         ref_ack     <= 1'b0;
         wr_ack      <= 1'b0;
         rd_ack      <= 1'b0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         ref_ack <= 1'b0;
         wr_ack  <= 1'b0;
         rd_ack  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (init_end) begin
                  state_r <= ST_ARB;
               end
            end
            ST_ARB: begin
               if (grant_type_s != CMD_NONE) begin
                  state_r   <= ST_ISSUE;
                  cmd_valid <= 1'b1;
                  cmd_type  <= grant_type_s;
                  cmd_addr  <= grant_addr_s;
                  busy      <= 1'b1;
                  if (grant_type_s != CMD_REF) begin
                     streak_r   <= streak_nxt_s;
                     last_dir_r <= grant_dir_s;
                  end
               end
            end
            ST_ISSUE: begin
               if (handshake_s) begin
                  state_r   <= ST_WAIT_DONE;
                  cmd_valid <= 1'b0;
                  case (cmd_type)
                     CMD_REF: ref_ack <= 1'b1;
                     CMD_WR:  wr_ack  <= 1'b1;
                     CMD_RD:  rd_ack  <= 1'b1;
                     default: ref_ack <= 1'b0;
                  endcase
               end
            end
            ST_WAIT_DONE: begin
               if (cmd_done || wd_expire_s) begin
                  state_r <= ST_ARB;
                  busy    <= 1'b0;
               end
               if (wd_expire_s && !cmd_done) begin
                  err_timeout <= 1'b1;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               cmd_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddr2_cmd_arbiter.sv
// Self-checking bench for ddr2_cmd_arbiter: directed scenarios plus random
// traffic, all checked against a transaction-level reference model.
module tb_ddr2_cmd_arbiter;

   localparam int AW  = 26;
   localparam int LIM = 4;
   localparam int TO  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          init_end = 1'b0;
   logic          ref_req = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
   logic [AW-1:0] wr_addr = '0, rd_addr = '0;
   logic          cmd_ready = 1'b0, cmd_done = 1'b0;
   logic          ref_ack, wr_ack, rd_ack, cmd_valid, busy, err_timeout;
   logic [1:0]    cmd_type;
   logic [AW-1:0] cmd_addr;

   ddr2_cmd_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM), .TIMEOUT_CYCLES(TO)) dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .init_end(init_end),
      .ref_req(ref_req), .ref_ack(ref_ack),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_addr(cmd_addr), .cmd_done(cmd_done), .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: which phase a command is in, plus direction history
   bit            m_started, m_arb, m_issue, m_wait, m_err;
   int            m_wcnt, m_type, m_last, m_streak;
   logic [AW-1:0] m_addr;

   // stimulus controls
   int  req_mode = 0;       // 0: drop on ack, 1: hold and re-request, 2: random
   bit  auto_seq = 1'b0;
   bit  ready_rand = 1'b0;
   bit  stray_en = 1'b0;
   int  done_lo = 1, done_hi = 1, done_cnt = 0;
   int  gr_q[$];
   bit  prev_valid = 1'b0;

   task automatic step();
      bit            s_ref, s_wr, s_rd, s_ready, s_done, s_rst, s_init;
      logic [AW-1:0] s_wa, s_ra;
      int            exp_ack, pick;
      @(posedge clk);
      s_ref = ref_req; s_wr = wr_req; s_rd = rd_req; s_wa = wr_addr; s_ra = rd_addr;
      s_ready = cmd_ready; s_done = cmd_done; s_rst = rst_n; s_init = init_end;
      exp_ack = 0;
      if (!s_rst) begin
         m_started = 0; m_arb = 0; m_issue = 0; m_wait = 0; m_err = 0;
         m_last = 1; m_streak = 0; m_type = 0; m_addr = '0;
      end else if (!m_started) begin
         if (s_init) begin
            m_started = 1; m_arb = 1;
         end
      end else if (m_arb) begin
         pick = 0;
         if (s_ref) pick = 3;
         else if (s_wr && s_rd) pick = (m_streak < LIM) ? m_last : 3 - m_last;
         else if (s_wr) pick = 1;
         else if (s_rd) pick = 2;
         if (pick != 0) begin
            if (pick != 3) begin
               if (pick == m_last) m_streak = (m_streak + 1 > LIM) ? LIM : m_streak + 1;
               else begin
                  m_streak = 1; m_last = pick;
               end
            end
            m_type = pick;
            m_addr = (pick == 1) ? s_wa : (pick == 2) ? s_ra : '0;
            m_arb = 0; m_issue = 1;
         end
      end else if (m_issue) begin
         if (s_ready) begin
            exp_ack = m_type; m_issue = 0; m_wait = 1; m_wcnt = 0;
         end
      end else if (m_wait) begin
         if (s_done) begin
            m_wait = 0; m_arb = 1;
         end
`ifdef ARB_TIMEOUT_EN
         else begin
            m_wcnt++;
            if (m_wcnt == TO) begin
               m_err = 1; m_wait = 0; m_arb = 1;
            end
         end
`endif
      end
      #1;
      check_eq("cmd_valid", cmd_valid, m_issue);
      if (m_issue || !s_rst) begin
         check_eq("cmd_type", cmd_type, m_type);
         check_eq("cmd_addr", cmd_addr, m_addr);
      end
      check_eq("acks", {ref_ack, wr_ack, rd_ack},
               {exp_ack == 3 ? 1'b1 : 1'b0, exp_ack == 1 ? 1'b1 : 1'b0, exp_ack == 2 ? 1'b1 : 1'b0});
      check_eq("busy", busy, m_issue | m_wait);
      check_eq("err_timeout", err_timeout, m_err);
      if (cmd_valid && !prev_valid) gr_q.push_back(int'(cmd_type));
      prev_valid = cmd_valid;
      // requester reactions
      if (exp_ack == 3) ref_req = (req_mode == 1);
      if (exp_ack == 1) begin
         wr_req = (req_mode == 1) || (req_mode == 2 && $urandom_range(1, 0) == 1);
         wr_addr = AW'($urandom);
      end
      if (exp_ack == 2) begin
         rd_req = (req_mode == 1) || (req_mode == 2 && $urandom_range(1, 0) == 1);
         rd_addr = AW'($urandom);
      end
      if (req_mode == 2) begin
         if (!wr_req && $urandom_range(3, 0) == 0) begin
            wr_req = 1'b1; wr_addr = AW'($urandom);
         end
         if (!rd_req && $urandom_range(3, 0) == 0) begin
            rd_req = 1'b1; rd_addr = AW'($urandom);
         end
         if (!ref_req && $urandom_range(15, 0) == 0) ref_req = 1'b1;
      end
      // sequencer reactions
      if (auto_seq) begin
         cmd_done = 1'b0;
         if (exp_ack != 0) done_cnt = $urandom_range(done_hi, done_lo);
         else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) cmd_done = 1'b1;
         end
         if (stray_en && m_issue && $urandom_range(7, 0) == 0) cmd_done = 1'b1;
      end
      if (ready_rand) cmd_ready = ($urandom_range(2, 0) != 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; init_end = 1'b0; ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      cmd_ready = 1'b0; cmd_done = 1'b0; done_cnt = 0;
      auto_seq = 1'b0; ready_rand = 1'b0; stray_en = 1'b0; req_mode = 0;
      step();
      step();
      rst_n = 1'b1;
      gr_q.delete();
   endtask

   task automatic wait_valid(input string tag, input int bound);
      int n = 0;
      while (!cmd_valid && n < bound) begin
         step();
         n++;
      end
      check_eq(tag, cmd_valid, 1'b1);
   endtask

   task automatic run_until_grants(input int cnt, input int bound);
      int n = 0;
      while (gr_q.size() < cnt && n < bound) begin
         step();
         n++;
      end
      check_eq("grant_count", gr_q.size(), cnt);
   endtask

   initial begin
      int exp_starve[12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};

      // reset values
      do_reset();
      check_eq("rst_valid", cmd_valid, 1'b0);
      check_eq("rst_type", cmd_type, 2'd0);
      check_eq("rst_addr", cmd_addr, '0);
      check_eq("rst_busy", busy, 1'b0);

      // init gating
      wr_req = 1'b1; wr_addr = 26'h0000155;
      for (int i = 0; i < 50; i++) step();
      check_eq("init_gate_valid", cmd_valid, 1'b0);
      init_end = 1'b1;
      wait_valid("init_release", 3);
      check_eq("init_release_type", cmd_type, 2'd1);
      cmd_ready = 1'b1; auto_seq = 1'b1; done_lo = 1; done_hi = 3;
      for (int i = 0; i < 10; i++) step();

      // single write
      do_reset();
      init_end = 1'b1;
      step();
      step();
      wr_addr = 26'h0001234; wr_req = 1'b1; cmd_ready = 1'b1;
      auto_seq = 1'b1; done_lo = 5; done_hi = 5;
      wait_valid("single_valid", 5);
      check_eq("single_type", cmd_type, 2'd1);
      check_eq("single_addr", cmd_addr, 26'h0001234);
      step();
      check_eq("single_valid_1cyc", cmd_valid, 1'b0);
      check_eq("single_wr_ack", wr_ack, 1'b1);
      step();
      check_eq("single_ack_1cyc", wr_ack, 1'b0);
      for (int i = 0; i < 8; i++) step();
      check_eq("single_back_arb", busy, 1'b0);

      // refresh priority
      do_reset();
      init_end = 1'b1;
      ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
      wr_addr = 26'h0aaaaaa; rd_addr = 26'h1555555;
      cmd_ready = 1'b1; auto_seq = 1'b1; done_lo = 1; done_hi = 3;
      run_until_grants(3, 80);
      if (gr_q.size() >= 3) begin
         check_eq("refprio_first", gr_q[0], 3);
         check_eq("refprio_second", gr_q[1], 1);
         check_eq("refprio_third", gr_q[2], 2);
      end

      // starvation bound
      do_reset();
      init_end = 1'b1; req_mode = 1;
      wr_req = 1'b1; rd_req = 1'b1; wr_addr = AW'($urandom); rd_addr = AW'($urandom);
      cmd_ready = 1'b1; auto_seq = 1'b1; done_lo = 1; done_hi = 2;
      run_until_grants(12, 300);
      for (int i = 0; i < 12; i++) begin
         if (i < gr_q.size()) check_eq($sformatf("starve_%0d", i), gr_q[i], exp_starve[i]);
      end

      // backpressure, stray done, dropped request, reset in WAIT_DONE
      do_reset();
      init_end = 1'b1;
      wr_req = 1'b1; wr_addr = 26'h2345678;
      wait_valid("bp_valid", 4);
      for (int i = 0; i < 10; i++) begin
         cmd_done = (i == 3);
         if (i == 5) wr_req = 1'b0;
         step();
      end
      cmd_done = 1'b0;
      check_eq("bp_hold_valid", cmd_valid, 1'b1);
      check_eq("bp_hold_addr", cmd_addr, 26'h2345678);
      check_eq("bp_no_ack", wr_ack, 1'b0);
      cmd_ready = 1'b1;
      step();
      check_eq("bp_ack", wr_ack, 1'b1);
      cmd_ready = 1'b0;
      step();
      step();
      check_eq("wait_busy", busy, 1'b1);
      rst_n = 1'b0;
      step();
      check_eq("rst_mid_valid", cmd_valid, 1'b0);
      check_eq("rst_mid_busy", busy, 1'b0);
      check_eq("rst_mid_acks", {ref_ack, wr_ack, rd_ack}, 3'b000);
      check_eq("rst_mid_type", cmd_type, 2'd0);
      rst_n = 1'b1;

      // missing cmd_done: watchdog or indefinite wait
      do_reset();
      init_end = 1'b1;
      wr_req = 1'b1; wr_addr = 26'h0000042; cmd_ready = 1'b1;
      wait_valid("wd_valid", 4);
      step();
      check_eq("wd_ack", wr_ack, 1'b1);
      for (int i = 0; i < TO; i++) step();
`ifdef ARB_TIMEOUT_EN
      check_eq("wd_err", err_timeout, 1'b1);
      check_eq("wd_busy", busy, 1'b0);
      rd_req = 1'b1; rd_addr = 26'h0000077;
      wait_valid("wd_next_valid", 4);
      check_eq("wd_next_type", cmd_type, 2'd2);
`else
      check_eq("nowd_err", err_timeout, 1'b0);
      check_eq("nowd_busy", busy, 1'b1);
      cmd_done = 1'b1;
      step();
      cmd_done = 1'b0;
      step();
`endif

      // randomized traffic
      do_reset();
      init_end = 1'b1; req_mode = 2; ready_rand = 1'b1;
      auto_seq = 1'b1; stray_en = 1'b1; done_lo = 1; done_hi = 6;
      for (int i = 0; i < 3000; i++) step();
      check_eq("random_grants_seen", (gr_q.size() > 100), 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
